// File: rtl/alu_rs_scheduler_pkg.sv
// Shared constants and entry layout for the ALU reservation station.
package alu_rs_scheduler_pkg;

    localparam int RS_DEPTH = 16;
    localparam int RS_IDX_W = 4;
    localparam int OP_W     = 6;
    localparam int TAG_W    = 4;
    localparam int DATA_W   = 32;

    localparam logic [OP_W-1:0] OP_ADD = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB = 6'd2;
    localparam logic [OP_W-1:0] OP_BEQ = 6'd16;
    localparam logic [OP_W-1:0] OP_JAL = 6'd24;
    localparam logic [OP_W-1:0] OP_AGU = 6'd32;

    typedef struct packed {
        logic              busy;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rob_tag;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] imm;
        logic              a_rdy;
        logic [DATA_W-1:0] a;
        logic [TAG_W-1:0]  a_tag;
        logic              b_rdy;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  b_tag;
    } rs_entry_t;

    // A CDB port hits an operand when it is broadcasting that operand's producer tag.
    function automatic logic cdb_hit(input logic ena, input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] tag);
        return ena && (cdb_tag == tag);
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_rs_pick.sv
// Lowest-index priority encoder used for free-slot and ready-entry selection.
module rs_pick #(
    parameter int N  = 16,
    parameter int IW = 4
) (
    input  logic [N-1:0]  i_vec,
    output logic          o_found,
    output logic [IW-1:0] o_idx
);

    // Scan high to low so the lowest set bit is the last (winning) assignment.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_found = 1'b1;
                o_idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Reservation station and one-per-cycle issue scheduler for the ALU.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
#(
    parameter int RS_DEPTH_P = RS_DEPTH,
    parameter int IDX_W      = RS_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [OP_W-1:0]   in_op,
    input  logic [TAG_W-1:0]  in_rob_tag,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              in_a_rdy,
    input  logic [DATA_W-1:0] in_a,
    input  logic [TAG_W-1:0]  in_a_tag,
    input  logic              in_b_rdy,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_b_tag,
    input  logic              cdb0_ena,
    input  logic [TAG_W-1:0]  cdb0_tag,
    input  logic [DATA_W-1:0] cdb0_data,
    input  logic              cdb1_ena,
    input  logic [TAG_W-1:0]  cdb1_tag,
    input  logic [DATA_W-1:0] cdb1_data,
    output logic              rs_full,
    output logic              alu_ena,
    output logic [OP_W-1:0]   alu_op,
    output logic [TAG_W-1:0]  alu_rob_tag,
    output logic [DATA_W-1:0] alu_pc,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] alu_imm
);

    rs_entry_t                r_ent [RS_DEPTH_P];
    logic [RS_DEPTH_P-1:0]    w_busy;
    logic [RS_DEPTH_P-1:0]    w_ready;
    logic                     w_free_found;
    logic [IDX_W-1:0]         w_free_idx;
    logic                     w_rdy_found;
    logic [IDX_W-1:0]         w_rdy_idx;
    logic                     w_dispatch;
    rs_entry_t                w_new;

    logic                     r_alu_ena;
    logic [OP_W-1:0]          r_alu_op;
    logic [TAG_W-1:0]         r_alu_rob_tag;
    logic [DATA_W-1:0]        r_alu_pc;
    logic [DATA_W-1:0]        r_alu_a;
    logic [DATA_W-1:0]        r_alu_b;
    logic [DATA_W-1:0]        r_alu_imm;

    // Busy/ready vectors come from registered state only, so a wakeup is seen next cycle.
    always_comb begin
        w_busy  = '0;
        w_ready = '0;
        for (int i = 0; i < RS_DEPTH_P; i++) begin
            w_busy[i]  = r_ent[i].busy;
            w_ready[i] = r_ent[i].busy && r_ent[i].a_rdy && r_ent[i].b_rdy;
        end
    end

    assign rs_full    = &w_busy;
    assign w_dispatch = in_valid && !rs_full && w_free_found;

    rs_pick #(.N(RS_DEPTH_P), .IW(IDX_W)) u_pick_free (
        .i_vec   (~w_busy),
        .o_found (w_free_found),
        .o_idx   (w_free_idx)
    );

    rs_pick #(.N(RS_DEPTH_P), .IW(IDX_W)) u_pick_ready (
        .i_vec   (w_ready),
        .o_found (w_rdy_found),
        .o_idx   (w_rdy_idx)
    );

    // New entry image with insert bypass: a result broadcast in the dispatch cycle is captured directly.
    always_comb begin
        w_new         = '0;
        w_new.busy    = 1'b1;
        w_new.op      = in_op;
        w_new.rob_tag = in_rob_tag;
        w_new.pc      = in_pc;
        w_new.imm     = in_imm;
        w_new.a_tag   = in_a_tag;
        w_new.b_tag   = in_b_tag;
        w_new.a_rdy   = in_a_rdy;
        w_new.a       = in_a;
        w_new.b_rdy   = in_b_rdy;
        w_new.b       = in_b;
        if (!in_a_rdy) begin
            if (cdb_hit(cdb0_ena, cdb0_tag, in_a_tag)) begin
                w_new.a_rdy = 1'b1;
                w_new.a     = cdb0_data;
            end else if (cdb_hit(cdb1_ena, cdb1_tag, in_a_tag)) begin
                w_new.a_rdy = 1'b1;
                w_new.a     = cdb1_data;
            end
        end
        if (!in_b_rdy) begin
            if (cdb_hit(cdb0_ena, cdb0_tag, in_b_tag)) begin
                w_new.b_rdy = 1'b1;
                w_new.b     = cdb0_data;
            end else if (cdb_hit(cdb1_ena, cdb1_tag, in_b_tag)) begin
                w_new.b_rdy = 1'b1;
                w_new.b     = cdb1_data;
            end
        end
    end

    // Entry array: wakeup snoop, issue release and dispatch write; flush drops everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RS_DEPTH_P; i++) r_ent[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH_P; i++) r_ent[i].busy <= 1'b0;
        end else begin
            for (int i = 0; i < RS_DEPTH_P; i++) begin
                if (r_ent[i].busy && !r_ent[i].a_rdy) begin
                    if (cdb_hit(cdb0_ena, cdb0_tag, r_ent[i].a_tag)) begin
                        r_ent[i].a_rdy <= 1'b1;
                        r_ent[i].a     <= cdb0_data;
                    end else if (cdb_hit(cdb1_ena, cdb1_tag, r_ent[i].a_tag)) begin
                        r_ent[i].a_rdy <= 1'b1;
                        r_ent[i].a     <= cdb1_data;
                    end
                end
                if (r_ent[i].busy && !r_ent[i].b_rdy) begin
                    if (cdb_hit(cdb0_ena, cdb0_tag, r_ent[i].b_tag)) begin
                        r_ent[i].b_rdy <= 1'b1;
                        r_ent[i].b     <= cdb0_data;
                    end else if (cdb_hit(cdb1_ena, cdb1_tag, r_ent[i].b_tag)) begin
                        r_ent[i].b_rdy <= 1'b1;
                        r_ent[i].b     <= cdb1_data;
                    end
                end
            end
            // The free slot is never the issuing slot (issuing implies busy), so no collision.
            if (w_rdy_found) r_ent[w_rdy_idx].busy <= 1'b0;
            if (w_dispatch)  r_ent[w_free_idx]     <= w_new;
        end
    end

    // Registered issue bundle; data regs hold when nothing issues or on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_alu_ena     <= 1'b0;
            r_alu_op      <= '0;
            r_alu_rob_tag <= '0;
            r_alu_pc      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_imm     <= '0;
        end else if (flush) begin
            r_alu_ena <= 1'b0;
        end else begin
            r_alu_ena <= w_rdy_found;
            if (w_rdy_found) begin
                r_alu_op      <= r_ent[w_rdy_idx].op;
                r_alu_rob_tag <= r_ent[w_rdy_idx].rob_tag;
                r_alu_pc      <= r_ent[w_rdy_idx].pc;
                r_alu_a       <= r_ent[w_rdy_idx].a;
                r_alu_b       <= r_ent[w_rdy_idx].b;
                r_alu_imm     <= r_ent[w_rdy_idx].imm;
            end
        end
    end

    assign alu_ena     = r_alu_ena;
    assign alu_op      = r_alu_op;
    assign alu_rob_tag = r_alu_rob_tag;
    assign alu_pc      = r_alu_pc;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_imm     = r_alu_imm;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: expected issues queued at stimulus, popped on alu_ena.
module tb_alu_rs_scheduler;
    import alu_rs_scheduler_pkg::*;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] imm;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n, flush, in_valid;
    logic [OP_W-1:0]   in_op;
    logic [TAG_W-1:0]  in_rob_tag, in_a_tag, in_b_tag, cdb0_tag, cdb1_tag;
    logic [DATA_W-1:0] in_pc, in_imm, in_a, in_b, cdb0_data, cdb1_data;
    logic              in_a_rdy, in_b_rdy, cdb0_ena, cdb1_ena;
    logic              rs_full, alu_ena;
    logic [OP_W-1:0]   alu_op;
    logic [TAG_W-1:0]  alu_rob_tag;
    logic [DATA_W-1:0] alu_pc, alu_a, alu_b, alu_imm;

    exp_t q[$];
    exp_t e;
    int   n_chk = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;

    alu_rs_scheduler dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_op(in_op), .in_rob_tag(in_rob_tag), .in_pc(in_pc), .in_imm(in_imm),
        .in_a_rdy(in_a_rdy), .in_a(in_a), .in_a_tag(in_a_tag),
        .in_b_rdy(in_b_rdy), .in_b(in_b), .in_b_tag(in_b_tag),
        .cdb0_ena(cdb0_ena), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
        .cdb1_ena(cdb1_ena), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
        .rs_full(rs_full), .alu_ena(alu_ena), .alu_op(alu_op), .alu_rob_tag(alu_rob_tag),
        .alu_pc(alu_pc), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; single-cycle pulses are dropped afterwards.
    task automatic step();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cdb0_ena = 1'b0;
        cdb1_ena = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic set_disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic ar, input logic [31:0] a, input logic [TAG_W-1:0] at,
                            input logic br, input logic [31:0] b, input logic [TAG_W-1:0] bt);
        in_valid = 1'b1; in_op = op; in_rob_tag = tag; in_pc = pc; in_imm = imm;
        in_a_rdy = ar; in_a = a; in_a_tag = at;
        in_b_rdy = br; in_b = b; in_b_tag = bt;
    endtask

    task automatic set_cdb(input int port, input logic [TAG_W-1:0] tag, input logic [31:0] d);
        if (port == 0) begin cdb0_ena = 1'b1; cdb0_tag = tag; cdb0_data = d; end
        else           begin cdb1_ena = 1'b1; cdb1_tag = tag; cdb1_data = d; end
    endtask

    task automatic push(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [31:0] pc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm);
        exp_t x;
        x.op = op; x.tag = tag; x.pc = pc; x.a = a; x.b = b; x.imm = imm;
        q.push_back(x);
    endtask

    // Fields of the i-th entry used in the full-station scenario.
    function automatic logic [OP_W-1:0]  f_op(input int i);  return OP_W'(i);        endfunction
    function automatic logic [TAG_W-1:0] f_tag(input int i); return TAG_W'(15 - i);  endfunction
    function automatic logic [31:0]      f_pc(input int i);  return 32'h400 + 32'(i) * 4; endfunction
    function automatic logic [31:0]      f_imm(input int i); return 32'(i) * 3;      endfunction
    function automatic logic [31:0]      f_b(input int i);   return 32'h1000 + 32'(i); endfunction

    task automatic push_full(input int i, input logic [31:0] a);
        push(f_op(i), f_tag(i), f_pc(i), a, f_b(i), f_imm(i));
    endtask

    // Issue monitor: every alu_ena must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && alu_ena === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexp_issue", {31'b0, alu_ena}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("iss_op",  {26'b0, alu_op}, {26'b0, e.op});
                chk("iss_tag", {28'b0, alu_rob_tag}, {28'b0, e.tag});
                chk("iss_pc",  alu_pc, e.pc);
                chk("iss_a",   alu_a, e.a);
                chk("iss_b",   alu_b, e.b);
                chk("iss_imm", alu_imm, e.imm);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; cdb0_ena = 1'b0; cdb1_ena = 1'b0;
        cdb0_tag = '0; cdb1_tag = '0; cdb0_data = '0; cdb1_data = '0;
        set_disp(OP_ADD, 4'd1, 32'h10, 32'h0, 1'b1, 32'd9, 4'd0, 1'b1, 32'd9, 4'd0);

        // 1: reset with in_valid held high writes nothing
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ena",  {31'b0, alu_ena}, 32'd0);
        chk("rst_full", {31'b0, rs_full}, 32'd0);
        chk("rst_op",   {26'b0, alu_op}, 32'd0);
        chk("rst_a",    alu_a, 32'd0);
        mon_en = 1'b1;
        repeat (3) step();

        // 2: ready dispatch issues two cycles later; data regs hold afterwards
        set_disp(OP_ADD, 4'd3, 32'h100, 32'h0, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
        push(OP_ADD, 4'd3, 32'h100, 32'd5, 32'd7, 32'h0);
        step(); @(negedge clk); chk("t2_ena_c1", {31'b0, alu_ena}, 32'd0);
        step(); @(negedge clk); chk("t2_ena_c2", {31'b0, alu_ena}, 32'd1);
        step(); @(negedge clk);
        chk("t2_idle_ena", {31'b0, alu_ena}, 32'd0);
        chk("t2_hold_op",  {26'b0, alu_op}, {26'b0, OP_ADD});
        chk("t2_hold_a",   alu_a, 32'd5);

        // 3: wakeup from cdb1 two cycles after dispatch
        set_disp(OP_SUB, 4'd6, 32'h200, 32'h4, 1'b0, 32'd0, 4'd2, 1'b1, 32'd1, 4'd0);
        push(OP_SUB, 4'd6, 32'h200, 32'h100, 32'd1, 32'h4);
        step(); step();
        set_cdb(1, 4'd2, 32'h100);
        step(); @(negedge clk); chk("t3_ena_wake", {31'b0, alu_ena}, 32'd0);
        step(); @(negedge clk); chk("t3_ena_iss",  {31'b0, alu_ena}, 32'd1);
        step();
        // insert bypass: CDB in the dispatch cycle
        set_disp(OP_BEQ, 4'd8, 32'h300, 32'h8, 1'b0, 32'd0, 4'd5, 1'b1, 32'd2, 4'd0);
        set_cdb(0, 4'd5, 32'hABC);
        push(OP_BEQ, 4'd8, 32'h300, 32'hABC, 32'd2, 32'h8);
        step(); @(negedge clk); chk("t3_byp_c1", {31'b0, alu_ena}, 32'd0);
        step(); @(negedge clk); chk("t3_byp_c2", {31'b0, alu_ena}, 32'd1);
        step();
        // A and B woken in the same cycle from different ports
        set_disp(OP_JAL, 4'd9, 32'h340, 32'h0, 1'b0, 32'd0, 4'd6, 1'b0, 32'd0, 4'd8);
        push(OP_JAL, 4'd9, 32'h340, 32'h66, 32'h88, 32'h0);
        step();
        set_cdb(0, 4'd6, 32'h66);
        set_cdb(1, 4'd8, 32'h88);
        step(); step(); @(negedge clk); chk("t3_ab_ena", {31'b0, alu_ena}, 32'd1);
        step(); step();

        // 4: fill all 16 slots; slot i waits on tag i
        for (int i = 0; i < RS_DEPTH; i++) begin
            set_disp(f_op(i), f_tag(i), f_pc(i), f_imm(i), 1'b0, 32'd0, TAG_W'(i), 1'b1, f_b(i), 4'd0);
            step();
        end
        @(negedge clk); chk("t4_full", {31'b0, rs_full}, 32'd1);
        set_disp(OP_AGU, 4'd1, 32'hDEAD, 32'h0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd1, 4'd0);
        step(); @(negedge clk); chk("t4_full_ign", {31'b0, rs_full}, 32'd1);
        set_cdb(0, 4'd7, 32'h77);
        push_full(7, 32'h77);
        step(); @(negedge clk);
        chk("t4_full_rdy", {31'b0, rs_full}, 32'd1);
        chk("t4_ena_rdy",  {31'b0, alu_ena}, 32'd0);
        step(); @(negedge clk);
        chk("t4_ena_iss",  {31'b0, alu_ena}, 32'd1);
        chk("t4_freed",    {31'b0, rs_full}, 32'd0);
        set_disp(OP_ADD, 4'd14, 32'h500, 32'h0, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
        push(OP_ADD, 4'd14, 32'h500, 32'd1, 32'd2, 32'h0);
        step(); @(negedge clk); chk("t4_refill", {31'b0, rs_full}, 32'd1);
        step(); @(negedge clk); chk("t4_refill_iss", {31'b0, alu_ena}, 32'd1);
        step();

        // 5: entries 4 and 9 woken together -> 4 then 9
        set_cdb(0, 4'd4, 32'h44);
        set_cdb(1, 4'd9, 32'h99);
        push_full(4, 32'h44);
        push_full(9, 32'h99);
        step(); step(); @(negedge clk); chk("t5_ena4", {31'b0, alu_ena}, 32'd1);
        step(); @(negedge clk); chk("t5_ena9", {31'b0, alu_ena}, 32'd1);
        step();
        // both ports carry tag 12 with different data: cdb0 captured
        set_cdb(0, 4'd12, 32'hC0);
        set_cdb(1, 4'd12, 32'hC1);
        push_full(12, 32'hC0);
        step(); step(); @(negedge clk); chk("t5_conf_ena", {31'b0, alu_ena}, 32'd1);
        step(); step();

        // 6: flush while entry 0 is issuing and a dispatch is presented
        set_cdb(0, 4'd0, 32'h5);
        step();
        flush = 1'b1;
        set_disp(OP_ADD, 4'd2, 32'h600, 32'h0, 1'b1, 32'd3, 4'd0, 1'b1, 32'd4, 4'd0);
        step(); @(negedge clk);
        chk("t6_ena",    {31'b0, alu_ena}, 32'd0);
        chk("t6_full",   {31'b0, rs_full}, 32'd0);
        chk("t6_hold_a", alu_a, 32'hC0);
        chk("t6_hold_op", {26'b0, alu_op}, {26'b0, f_op(12)});
        for (int t = 1; t < 16; t++) begin
            set_cdb(0, TAG_W'(t), 32'hF00 + 32'(t));
            step();
        end
        step(); step();
        // station usable after flush
        set_disp(OP_SUB, 4'd11, 32'h700, 32'h1, 1'b1, 32'd8, 4'd0, 1'b1, 32'd9, 4'd0);
        push(OP_SUB, 4'd11, 32'h700, 32'd8, 32'd9, 32'h1);
        step(); step(); @(negedge clk); chk("t6_post_iss", {31'b0, alu_ena}, 32'd1);
        step();

        // reset mid-operation discards waiting entries and clears data regs
        set_disp(OP_AGU, 4'd1, 32'h800, 32'h0, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
        step();
        rst_n = 1'b0;
        set_cdb(0, 4'd1, 32'h11);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst2_ena", {31'b0, alu_ena}, 32'd0);
        chk("rst2_a",   alu_a, 32'd0);
        set_cdb(0, 4'd1, 32'h11);
        repeat (4) step();

        chk("sb_empty", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
